// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes RISC-V load/store funct3, aligns lanes for a
// single-beat memory access and returns an extended, error-tagged response.
module lsu_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          rsp_err_code,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and payloads hold while valid waits for ready.
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          funct3_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [31:0]         wait_cnt;
  logic [OFF_W-1:0]    req_off;
  logic [OFF_W-1:0]    off_q;
  logic                illegal;
  logic                misaligned;

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] sz,
                                                    input logic zext);
    logic [6:0]        nbits;
    logic [DATA_W-1:0] mask;
    logic              sign;
    nbits = 7'd8 << sz;
    if (nbits > 7'(DATA_W)) nbits = 7'(DATA_W);
    mask = {DATA_W{1'b1}} << nbits;
    sign = !zext && (|(d & (DATA_W'(1) << (nbits - 7'd1))));
    return sign ? (d | mask) : (d & ~mask);
  endfunction

  always_comb begin
    req_off    = req_addr[OFF_W-1:0];
    illegal    = (req_write && req_funct3[2])
              || (DATA_W == 32 && req_funct3[1:0] == 2'b11)
              || (DATA_W == 32 && !req_write && req_funct3 == 3'b110);
    misaligned = (req_off & OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1)) != '0;
  end

  assign off_q     = addr_q[OFF_W-1:0];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Lane outputs are gated by state so reset clears them without waiting for an edge.
  assign mem_address     = (state == ACCESS) ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_byte_enable = (state == ACCESS)
                         ? BE_W'((9'd1 << (4'd1 << funct3_q[1:0])) - 9'd1) << off_q : '0;
  assign mem_wdata       = (state == ACCESS) ? (wdata_q << {off_q, 3'b000}) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      wait_cnt     <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_err_code <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            funct3_q  <= req_funct3;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            if (illegal) begin
              rsp_err      <= 1'b1;
              rsp_err_code <= 2'd2;
              state        <= RESP;
            end else if (misaligned) begin
              rsp_err      <= 1'b1;
              rsp_err_code <= 2'd1;
              state        <= RESP;
            end else begin
              rsp_err      <= 1'b0;
              rsp_err_code <= 2'd0;
              mem_read     <= !req_write;
              mem_write    <= req_write;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // A completion in the final wait cycle takes priority over the timeout.
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_rdata <= write_q ? '0
                       : extend_load(mem_rdata >> {off_q, 3'b000}, funct3_q[1:0], funct3_q[2]);
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
            if (TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1)) begin
              mem_read     <= 1'b0;
              mem_write    <= 1'b0;
              rsp_err      <= 1'b1;
              rsp_err_code <= 2'd3;
              state        <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_err_code <= 2'd0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed load/store vectors with a memory responder, an expected
// queue per channel (memory strobe, response) and a negedge monitor that pops and compares.
module tb_lsu_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err_code;
  logic          mem_read, mem_write, mem_resp;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byte_enable;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          r64_valid, r64_ready, r64_write;
  logic [2:0]    r64_funct3;
  logic [AW-1:0] r64_addr;
  logic [63:0]   r64_wdata;
  logic          r64_rsp_valid, r64_rsp_err;
  logic [63:0]   r64_rsp_rdata;
  logic [1:0]    r64_rsp_code;
  logic          r64_mem_read, r64_mem_write, r64_mem_resp;
  logic [AW-1:0] r64_mem_address;
  logic [7:0]    r64_mem_be;
  logic [63:0]   r64_mem_wdata, r64_mem_rdata;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [7:0]    len;
  } mem_exp_t;

  mem_exp_t         mem_q[$];
  logic [DW+2:0]    exp_q[$];   // {err, code, rdata}
  int               total = 0;
  int               bad = 0;
  int               mem_delay = 1;  // 0 = memory never answers

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_err_code(rsp_err_code),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  lsu_ctrl #(.DATA_W(64), .ADDR_W(AW), .TIMEOUT(0)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(r64_valid), .req_ready(r64_ready), .req_write(r64_write),
    .req_funct3(r64_funct3), .req_addr(r64_addr), .req_wdata(r64_wdata),
    .rsp_valid(r64_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(r64_rsp_rdata),
    .rsp_err(r64_rsp_err), .rsp_err_code(r64_rsp_code),
    .mem_read(r64_mem_read), .mem_write(r64_mem_write), .mem_address(r64_mem_address),
    .mem_byte_enable(r64_mem_be), .mem_wdata(r64_mem_wdata),
    .mem_rdata(r64_mem_rdata), .mem_resp(r64_mem_resp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_mem(input logic wr, input logic [AW-1:0] a, input logic [3:0] be,
                            input logic [DW-1:0] wd, input int len);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.be = be; e.wdata = wd; e.len = 8'(len);
    mem_q.push_back(e);
  endtask

  task automatic expect_rsp(input logic err, input logic [1:0] code, input logic [DW-1:0] rd);
    exp_q.push_back({err, code, rd});
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    int n;
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (n == 100) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && mem_q.size() == 0 && req_ready) break;
    end
    if (n == 100) check("drain_timeout", 64'(exp_q.size() + mem_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Memory responder: pulses mem_resp in the mem_delay-th strobe cycle.
  initial begin
    int strobe_n;
    strobe_n = 0;
    mem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) strobe_n++;
      else strobe_n = 0;
      mem_resp = (mem_read || mem_write) && mem_delay != 0 && strobe_n == mem_delay;
    end
  end

  // Monitor: checks each new strobe and every response cycle against the queues.
  initial begin
    mem_exp_t      cur;
    logic [DW+2:0] e;
    logic          prev, have, strobe;
    int            len;
    prev = 1'b0; have = 1'b0; len = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0; have = 1'b0; len = 0;
      end else begin
        strobe = mem_read | mem_write;
        if (strobe && !prev) begin
          len = 0;
          if (mem_q.size() == 0) check("unexpected_strobe", 64'(mem_address), 64'hFFFF_FFFF_FFFF);
          else begin
            cur = mem_q.pop_front();
            have = 1'b1;
            check("mem_write", 64'(mem_write), 64'(cur.wr));
            check("mem_read", 64'(mem_read), 64'(!cur.wr));
            check("mem_address", 64'(mem_address), 64'(cur.addr));
            check("mem_byte_enable", 64'(mem_byte_enable), 64'(cur.be));
            check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
          end
        end
        if (strobe) len++;
        if (!strobe && prev && have) begin
          check("strobe_len", 64'(len), 64'(cur.len));
          have = 1'b0;
        end
        prev = strobe;
        if (rsp_valid) begin
          if (exp_q.size() == 0) check("unexpected_rsp", 64'(rsp_err_code), 64'hFFFF_FFFF_FFFF);
          else begin
            e = exp_q[0];
            check("rsp_err", 64'(rsp_err), 64'(e[DW+2]));
            check("rsp_err_code", 64'(rsp_err_code), 64'(e[DW+1:DW]));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
            if (rsp_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; mem_rdata = '0;
    r64_valid = 1'b0; r64_write = 1'b0; r64_funct3 = '0; r64_addr = '0; r64_wdata = '0;
    r64_mem_rdata = '0; r64_mem_resp = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_mem_read", 64'(mem_read | mem_write), 64'd0);
    check("reset_be", 64'(mem_byte_enable), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("first_cycle_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // sb at 0x1003
    mem_delay = 2;
    expect_mem(1'b1, 32'h1000, 4'b1000, 32'hAB00_0000, 2);
    expect_rsp(1'b0, 2'd0, 32'h0);
    issue(1'b1, 3'b000, 32'h1003, 32'h0000_00AB);
    wait_idle();

    // lh / lhu at 0x2002
    mem_rdata = 32'h8001_1234; mem_delay = 1;
    expect_mem(1'b0, 32'h2000, 4'b1100, 32'h0, 1);
    expect_rsp(1'b0, 2'd0, 32'hFFFF_8001);
    issue(1'b0, 3'b001, 32'h2002, 32'h0);
    wait_idle();
    mem_delay = 3;
    expect_mem(1'b0, 32'h2000, 4'b1100, 32'h0, 3);
    expect_rsp(1'b0, 2'd0, 32'h0000_8001);
    issue(1'b0, 3'b101, 32'h2002, 32'h0);
    wait_idle();

    // lb / lbu at 0x4003
    mem_rdata = 32'h80FF_FFFF; mem_delay = 1;
    expect_mem(1'b0, 32'h4000, 4'b1000, 32'h0, 1);
    expect_rsp(1'b0, 2'd0, 32'hFFFF_FF80);
    issue(1'b0, 3'b000, 32'h4003, 32'h0);
    wait_idle();
    expect_mem(1'b0, 32'h4000, 4'b1000, 32'h0, 1);
    expect_rsp(1'b0, 2'd0, 32'h0000_0080);
    issue(1'b0, 3'b100, 32'h4003, 32'h0);
    wait_idle();

    // sw, sh
    expect_mem(1'b1, 32'h5000, 4'b1111, 32'hDEAD_BEEF, 1);
    expect_rsp(1'b0, 2'd0, 32'h0);
    issue(1'b1, 3'b010, 32'h5000, 32'hDEAD_BEEF);
    wait_idle();
    expect_mem(1'b1, 32'h5000, 4'b1100, 32'h1234_0000, 1);
    expect_rsp(1'b0, 2'd0, 32'h0);
    issue(1'b1, 3'b001, 32'h5002, 32'h0000_1234);
    wait_idle();

    // Error paths: misaligned lw, ld on 32-bit, store funct3[2], lwu misaligned (illegal wins)
    expect_rsp(1'b1, 2'd1, 32'h0);
    issue(1'b0, 3'b010, 32'h3001, 32'h0);
    @(negedge clk);
    check("err_latency_rsp_valid", 64'(rsp_valid), 64'd1);
    check("err_no_strobe", 64'(mem_read | mem_write), 64'd0);
    wait_idle();
    expect_rsp(1'b1, 2'd2, 32'h0);
    issue(1'b0, 3'b011, 32'h3000, 32'h0);
    wait_idle();
    expect_rsp(1'b1, 2'd2, 32'h0);
    issue(1'b1, 3'b100, 32'h3000, 32'h0);
    wait_idle();
    expect_rsp(1'b1, 2'd2, 32'h0);
    issue(1'b0, 3'b110, 32'h3001, 32'h0);
    wait_idle();

    // Timeout, then completion in the last allowed cycle
    mem_delay = 0;
    expect_mem(1'b0, 32'h6000, 4'b1111, 32'h0, 8);
    expect_rsp(1'b1, 2'd3, 32'h0);
    issue(1'b0, 3'b010, 32'h6000, 32'h0);
    wait_idle();
    mem_delay = 8; mem_rdata = 32'hCAFE_F00D;
    expect_mem(1'b0, 32'h6000, 4'b1111, 32'h0, 8);
    expect_rsp(1'b0, 2'd0, 32'hCAFE_F00D);
    issue(1'b0, 3'b010, 32'h6000, 32'h0);
    wait_idle();

    // Response backpressure with a second request pending
    rsp_ready = 1'b0; mem_delay = 1; mem_rdata = 32'h1122_3344;
    expect_mem(1'b0, 32'h7000, 4'b1111, 32'h0, 1);
    expect_rsp(1'b0, 2'd0, 32'h1122_3344);
    issue(1'b0, 3'b010, 32'h7000, 32'h0);
    req_valid = 1'b1; req_addr = 32'h7100; req_funct3 = 3'b010; req_write = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();

    // Reset in the third ACCESS cycle abandons the load
    mem_delay = 0;
    expect_mem(1'b0, 32'h9000, 4'b1111, 32'h0, 8);
    issue(1'b0, 3'b010, 32'h9000, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_mem_read", 64'(mem_read), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_be", 64'(mem_byte_enable), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("abandoned_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    mem_delay = 2; mem_rdata = 32'h55AA_55AA;
    expect_mem(1'b0, 32'hA004, 4'b1111, 32'h0, 2);
    expect_rsp(1'b0, 2'd0, 32'h55AA_55AA);
    issue(1'b0, 3'b010, 32'hA004, 32'h0);
    wait_idle();

    // 64-bit instance: ld at 0x8, then lwu and lw at 0x4
    r64_valid = 1'b1; r64_funct3 = 3'b011; r64_addr = 32'h8;
    @(posedge clk); #1 r64_valid = 1'b0;
    @(negedge clk);
    check("d64_ld_read", 64'(r64_mem_read), 64'd1);
    check("d64_ld_be", 64'(r64_mem_be), 64'hFF);
    check("d64_ld_addr", 64'(r64_mem_address), 64'h8);
    r64_mem_rdata = 64'h8000_0000_1234_5678; r64_mem_resp = 1'b1;
    @(posedge clk); #1 r64_mem_resp = 1'b0;
    @(negedge clk);
    check("d64_ld_valid", 64'(r64_rsp_valid), 64'd1);
    check("d64_ld_rdata", r64_rsp_rdata, 64'h8000_0000_1234_5678);
    check("d64_ld_err", 64'(r64_rsp_err), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      r64_valid = 1'b1; r64_funct3 = (k == 0) ? 3'b110 : 3'b010; r64_addr = 32'h4;
      @(posedge clk); #1 r64_valid = 1'b0;
      @(negedge clk);
      check("d64_w_be", 64'(r64_mem_be), 64'hF0);
      r64_mem_rdata = 64'h89AB_CDEF_0000_0000; r64_mem_resp = 1'b1;
      @(posedge clk); #1 r64_mem_resp = 1'b0;
      @(negedge clk);
      check("d64_w_rdata", r64_rsp_rdata,
            (k == 0) ? 64'h0000_0000_89AB_CDEF : 64'hFFFF_FFFF_89AB_CDEF);
    end
    repeat (2) @(posedge clk);

    check("queues_empty", 64'(exp_q.size() + mem_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 0, the maximum wait cycles for mem_resp; 0 disables the timeout.
REQ-004 Ports; reset is asynchronous and active-low. All non-clock/reset signals are synchronous to clk.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  access request
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV load/store funct3
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  extended load data
- rsp_err  out  1  access failed
- rsp_err_code  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  aligned word address
- mem_byte_enable  out  DATA_W/8  byte lanes
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_rdata  in  DATA_W  memory read data
- mem_resp  in  1  memory completion

Function
REQ-005 SHALL implement states IDLE, ACCESS, RESP; reset state is IDLE.
REQ-006 SHALL drive req_ready=1 only in IDLE, and SHALL accept a request on a clock edge with req_valid&req_ready, registering addr, funct3, write and wdata.
REQ-007 SHALL decode size as 2^funct3[1:0] bytes; size 8 with DATA_W=32 is illegal, a store with funct3[2]=1 is illegal, and load funct3 110 (lwu) is legal only for DATA_W=64.
REQ-008 SHALL treat an access as misaligned when the byte offset addr[log2(DATA_W/8)-1:0] is not a multiple of the size.
REQ-009 An illegal or misaligned request SHALL go IDLE->RESP with no memory strobe; illegal takes precedence over misaligned for rsp_err_code.
REQ-010 Otherwise the block SHALL go IDLE->ACCESS and assert exactly one of mem_read/mem_write on every ACCESS cycle.
REQ-011 In ACCESS, outputs SHALL be: mem_address = addr with its offset bits zeroed; mem_byte_enable = ((1<<size)-1)<<offset; mem_wdata = wdata<<(8*offset).
REQ-012 On mem_resp in ACCESS, the block SHALL capture the response and go to RESP on the next edge, deasserting the strobe from that edge on.
REQ-013 Captured load data SHALL be (mem_rdata>>(8*offset)) truncated to size, then sign-extended, or zero-extended when funct3[2]=1; captured store data SHALL be 0.
REQ-014 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_resp.
REQ-015 When TIMEOUT≠0 and the counter reaches TIMEOUT, the block SHALL go to RESP with rsp_err=1 and code 3.
REQ-016 If mem_resp arrives in the same cycle the counter reaches TIMEOUT, mem_resp SHALL win.
REQ-017 In RESP, rsp_valid=1, and rsp_rdata/rsp_err/rsp_err_code SHALL hold stable until rsp_valid&rsp_ready, after which the block returns to IDLE.
REQ-018 The earliest next request is accepted one cycle after the response handshake.
REQ-019 Latency: a request accepted at edge N has its strobe in cycle N+1; mem_resp in cycle K gives rsp_valid from cycle K+1; an error response gives rsp_valid in cycle N+1.
REQ-020 mem_resp outside ACCESS SHALL be ignored; mem_byte_enable and mem_wdata SHALL be 0 outside ACCESS.
REQ-021 Requests SHALL never overlap: at most one is outstanding.

Reset
REQ-022 While rst=0, the block SHALL be in IDLE and hold all outputs at 0 except req_ready; this includes immediately dropping mem_read/mem_write mid-ACCESS.
REQ-023 req_ready SHALL be 1 in the first cycle after rst deasserts, and an abandoned access SHALL produce no response.

Verification
REQ-024 sb, addr 0x1003, wdata 0xAB (DATA_W=32) -> mem_address 0x1000, byte_enable 1000b, mem_wdata 0xAB000000; mem_resp -> rsp_err=0.
REQ-025 lh at 0x2002 with mem_rdata 0x80011234 -> rsp_rdata 0xFFFF8001; lhu at the same address -> 0x00008001.
REQ-026 lw at 0x3001 -> no strobe ever, rsp_valid in cycle N+1, err=1, code 1; funct3 011 with DATA_W=32 -> code 2.
REQ-027 TIMEOUT=8, mem_resp held 0 -> mem_read high for 8 cycles then low, code 3; mem_resp on cycle 8 instead -> normal response.
REQ-028 rsp_ready low for 5 cycles with req_valid high -> rsp_valid and data stable, req_ready 0, no second request accepted.
REQ-029 rst pulled low in cycle 3 of ACCESS -> mem_read 0 in the same cycle, no response; after release, req_ready=1 and a new lw completes normally; DATA_W=64 ld at 0x8 -> byte_enable 0xFF.
